// File: rtl/id_match_stats.sv
// Per-stream statistics for the identifier-recognition FSM: characters seen,
// match episodes, current/longest match run; freezes on the terminator character.
module id_match_stats #(
    parameter int unsigned CNT_W   = 8,
    parameter logic [7:0]  TERM    = 8'h5C,
    parameter logic [7:0]  IDLE_CH = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic             match,
    input  logic             clr,
    output logic [CNT_W-1:0] char_cnt,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] run_cur,
    output logic [CNT_W-1:0] run_max,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic             match_d, match_d_nxt;
    logic [CNT_W-1:0] char_cnt_nxt, match_cnt_nxt, run_cur_nxt, run_max_nxt;
    logic             is_idle, is_term, proc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign is_idle = (char == IDLE_CH);
    assign is_term = (char == TERM);

    // Next state and next counter values; clr overrides everything on its edge.
    always_comb begin
        state_nxt     = state;
        char_cnt_nxt  = char_cnt;
        match_cnt_nxt = match_cnt;
        run_cur_nxt   = run_cur;
        run_max_nxt   = run_max;
        match_d_nxt   = match_d;
        proc          = 1'b0;

        case (state)
            S_IDLE: begin
                if (is_term) begin
                    state_nxt = S_DONE;
                end else if (!is_idle) begin
                    state_nxt = S_COUNT;
                    proc      = 1'b1;
                end
            end
            S_COUNT: begin
                if (is_term) begin
                    state_nxt = S_DONE;
                end else if (!is_idle) begin
                    proc = 1'b1;
                end
            end
            default: ;
        endcase

        if (proc) begin
            char_cnt_nxt = sat_inc(char_cnt);
            if (match && !match_d) begin
                match_cnt_nxt = sat_inc(match_cnt);
            end
            run_cur_nxt = match ? sat_inc(run_cur) : '0;
            // Compare against the new run so run_max never trails run_cur.
            run_max_nxt = (run_cur_nxt > run_max) ? run_cur_nxt : run_max;
            match_d_nxt = match;
        end

        if (clr) begin
            state_nxt     = S_IDLE;
            char_cnt_nxt  = '0;
            match_cnt_nxt = '0;
            run_cur_nxt   = '0;
            run_max_nxt   = '0;
            match_d_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            char_cnt  <= '0;
            match_cnt <= '0;
            run_cur   <= '0;
            run_max   <= '0;
            match_d   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            char_cnt  <= char_cnt_nxt;
            match_cnt <= match_cnt_nxt;
            run_cur   <= run_cur_nxt;
            run_max   <= run_max_nxt;
            match_d   <= match_d_nxt;
            done      <= (state_nxt == S_DONE);
            busy      <= (state_nxt == S_COUNT);
        end
    end

endmodule

// File: tb/tb_id_match_stats.sv
// Bench for id_match_stats: reference model feeds a scoreboard queue, plus
// per-scenario constant checks against known results, on 8-bit and 4-bit counters.
module tb_id_match_stats;

    localparam logic [7:0] TERM = 8'h5C;
    localparam logic [7:0] IDLE = 8'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       match;
    logic [7:0] char;

    logic [7:0] cc8, mc8, rc8, rm8;
    logic       done8, busy8;
    logic [3:0] cc4, mc4, rc4, rm4;
    logic       done4, busy4;

    always #5 clk = ~clk;

    id_match_stats #(.CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .char(char), .match(match), .clr(clr),
        .char_cnt(cc8), .match_cnt(mc8), .run_cur(rc8), .run_max(rm8),
        .done(done8), .busy(busy8)
    );

    id_match_stats #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .char(char), .match(match), .clr(clr),
        .char_cnt(cc4), .match_cnt(mc4), .run_cur(rc4), .run_max(rm4),
        .done(done4), .busy(busy4)
    );

    typedef struct {
        int cc; int mc; int rc; int rm; bit dn; bit bz;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Unbounded reference model; saturation applied when comparing.
    int m_state = 0;  // 0 idle, 1 count, 2 done
    int m_cc = 0, m_mc = 0, m_rc = 0, m_rm = 0;
    bit m_md = 1'b0;

    function automatic int clampv(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_clear();
        m_state = 0; m_cc = 0; m_mc = 0; m_rc = 0; m_rm = 0; m_md = 1'b0;
    endtask

    task automatic step(input logic [7:0] ch, input logic m, input logic c);
        exp_t e;
        bit   take;
        @(negedge clk);
        char = ch; match = m; clr = c;
        take = 1'b0;
        if (c) begin
            model_clear();
        end else if (m_state != 2) begin
            if (ch == TERM) m_state = 2;
            else if (ch != IDLE) begin m_state = 1; take = 1'b1; end
        end
        if (take) begin
            m_cc++;
            if (m && !m_md) m_mc++;
            m_rc = m ? m_rc + 1 : 0;
            if (m_rc > m_rm) m_rm = m_rc;
            m_md = m;
        end
        e.cc = m_cc; e.mc = m_mc; e.rc = m_rc; e.rm = m_rm;
        e.dn = (m_state == 2); e.bz = (m_state == 1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        char = IDLE; match = 1'b0; clr = 1'b0;
    endtask

    // Scoreboard: pop one expectation per edge that had stimulus.
    always @(posedge clk) begin
        exp_t        e;
        logic [33:0] a8, x8;
        logic [17:0] a4, x4;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            a8 = {cc8, mc8, rc8, rm8, done8, busy8};
            x8 = {8'(clampv(e.cc, 255)), 8'(clampv(e.mc, 255)),
                  8'(clampv(e.rc, 255)), 8'(clampv(e.rm, 255)), e.dn, e.bz};
            a4 = {cc4, mc4, rc4, rm4, done4, busy4};
            x4 = {4'(clampv(e.cc, 15)), 4'(clampv(e.mc, 15)),
                  4'(clampv(e.rc, 15)), 4'(clampv(e.rm, 15)), e.dn, e.bz};
            n_checks++;
            if (a8 !== x8) $display("FAIL sb_w8 t=%0t actual=%h required=%h", $time, a8, x8);
            else n_pass++;
            n_checks++;
            if (a4 !== x4) $display("FAIL sb_w4 t=%0t actual=%h required=%h", $time, a4, x4);
            else n_pass++;
        end
    end

    task automatic test_reset();
        reset = 1'b0; clr = 1'b0; match = 1'b0; char = IDLE;
        #2;
        n_checks++;
        if ({cc8, mc8, rc8, rm8, done8, busy8} !== 34'd0)
            $display("FAIL reset_w8 actual=%h required=0", {cc8, mc8, rc8, rm8, done8, busy8});
        else n_pass++;
        char = 8'h61; match = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({cc4, mc4, rc4, rm4, done4, busy4} !== 18'd0)
            $display("FAIL reset_hold_w4 actual=%h required=0", {cc4, mc4, rc4, rm4, done4, busy4});
        else n_pass++;
        char = IDLE; match = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    task automatic test_identifier();
        string s;
        bit    mp [8] = '{0, 1, 1, 1, 1, 1, 1, 1};
        s = "abcd1234";
        for (int i = 0; i < 8; i++) step(s[i], mp[i], 1'b0);
        step(TERM, 1'b0, 1'b0);
        n_checks++;
        if ({cc8, mc8, rc8, rm8, done8, busy8} !== {8'd8, 8'd1, 8'd7, 8'd7, 1'b1, 1'b0})
            $display("FAIL identifier actual=%h required=%h", {cc8, mc8, rc8, rm8, done8, busy8},
                     {8'd8, 8'd1, 8'd7, 8'd7, 1'b1, 1'b0});
        else n_pass++;
        step(IDLE, 1'b0, 1'b1);
    endtask

    task automatic test_episodes();
        bit mp [8] = '{1, 1, 0, 1, 0, 1, 1, 1};
        for (int i = 0; i < 8; i++) step(8'(8'h61 + i), mp[i], 1'b0);
        step(TERM, 1'b1, 1'b0);
        n_checks++;
        if ({cc8, mc8, rc8, rm8} !== {8'd8, 8'd3, 8'd3, 8'd3})
            $display("FAIL episodes actual=%h required=%h", {cc8, mc8, rc8, rm8},
                     {8'd8, 8'd3, 8'd3, 8'd3});
        else n_pass++;
        step(IDLE, 1'b0, 1'b1);
    endtask

    task automatic test_idle_gap();
        step(8'h78, 1'b1, 1'b0);
        step(IDLE, 1'b0, 1'b0);
        step(8'h79, 1'b1, 1'b0);
        step(TERM, 1'b0, 1'b0);
        n_checks++;
        if ({cc8, mc8, rc8, rm8} !== {8'd2, 8'd1, 8'd2, 8'd2})
            $display("FAIL idle_gap actual=%h required=%h", {cc8, mc8, rc8, rm8},
                     {8'd2, 8'd1, 8'd2, 8'd2});
        else n_pass++;
        step(IDLE, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) step(8'h41, 1'b1, 1'b0);
        n_checks++;
        if ({cc4, mc4, rc4, rm4} !== {4'd15, 4'd1, 4'd15, 4'd15})
            $display("FAIL sat_run_w4 actual=%h required=%h", {cc4, mc4, rc4, rm4},
                     {4'd15, 4'd1, 4'd15, 4'd15});
        else n_pass++;
        n_checks++;
        if (cc8 !== 8'd20) $display("FAIL sat_cc_w8 actual=%0d required=20", cc8);
        else n_pass++;
        step(TERM, 1'b0, 1'b0);
        step(IDLE, 1'b0, 1'b1);
        for (int i = 0; i < 34; i++) step(8'h42, 1'(i % 2 == 0), 1'b0);
        n_checks++;
        if ({mc4, mc8} !== {4'd15, 8'd17})
            $display("FAIL sat_episodes actual=%h required=%h", {mc4, mc8}, {4'd15, 8'd17});
        else n_pass++;
        step(TERM, 1'b0, 1'b0);
        step(IDLE, 1'b0, 1'b1);
    endtask

    task automatic test_term_first();
        step(TERM, 1'b1, 1'b0);
        n_checks++;
        if ({cc8, mc8, rc8, rm8, done8, busy8} !== {32'd0, 1'b1, 1'b0})
            $display("FAIL term_first actual=%h required=%h", {cc8, mc8, rc8, rm8, done8, busy8},
                     {32'd0, 1'b1, 1'b0});
        else n_pass++;
        step(8'h71, 1'b1, 1'b0);
        step(8'h72, 1'b0, 1'b0);
        step(IDLE, 1'b0, 1'b1);
        n_checks++;
        if ({done8, busy8, cc8} !== 10'd0)
            $display("FAIL term_clr actual=%h required=0", {done8, busy8, cc8});
        else n_pass++;
    endtask

    task automatic test_async_reset();
        step(8'h61, 1'b1, 1'b0);
        step(8'h62, 1'b1, 1'b0);
        step(8'h63, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({cc8, mc8, rc8, rm8, done8, busy8} !== 34'd0)
            $display("FAIL async_reset actual=%h required=0", {cc8, mc8, rc8, rm8, done8, busy8});
        else n_pass++;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        step(8'h7A, 1'b1, 1'b0);
        step(8'h77, 1'b1, 1'b1);
        n_checks++;
        if ({cc8, mc8, busy8} !== 17'd0)
            $display("FAIL clr_with_char actual=%h required=0", {cc8, mc8, busy8});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_identifier();
        test_episodes();
        test_idle_gap();
        test_saturation();
        test_term_first();
        test_async_reset();
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_drain actual=%0d required=0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
